// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg : PS/2 set-2 prefix constants, entry width and prefix FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam int         ENTRY_W = 12;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXT    = 2'd1;
  localparam logic [1:0] BRK    = 2'd2;
  localparam logic [1:0] EXTBRK = 2'd3;

  // Hex-aligned entry: {valid, 0, ext, brk, code}
  function automatic logic [ENTRY_W-1:0] make_entry(input logic ext, input logic brk,
                                                   input logic [7:0] code);
    return {1'b1, 1'b0, ext, brk, code};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_prefix_fsm.sv
// ----------------------------------------------------------------------------
// ps2_prefix_fsm : folds E0/F0 prefixes into annotated commit strobes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ps2_prefix_fsm
  import ps2_pkg::*;
#(
  parameter int FILTER_PREFIX = 1,
  parameter int TIMEOUT_CYC   = 1048576
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic [7:0] code_i,
  input  logic       code_valid_i,
  output logic       commit_o,
  output logic [7:0] code_o,
  output logic       ext_o,
  output logic       brk_o,
  output logic       pending_o
);

  localparam int            TO_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]      state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            commit_q, commit_d;
  logic [7:0]      code_q, code_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;

  always_comb begin
    state_d  = state_q;
    to_d     = to_q;
    commit_d = 1'b0;
    code_d   = code_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    if (clear_i) begin
      state_d = IDLE;
      to_d    = '0;
    end else if (code_valid_i) begin
      to_d   = '0;
      code_d = code_i;
      if (FILTER_PREFIX == 0) begin
        commit_d = 1'b1;
        ext_d    = 1'b0;
        brk_d    = 1'b0;
        state_d  = IDLE;
      end else if (code_i == PS2_EXT) begin
        // A fresh E0 always restarts the sequence, discarding any stale break
        state_d = EXT;
      end else if (code_i == PS2_BRK) begin
        state_d = (state_q == EXT || state_q == EXTBRK) ? EXTBRK : BRK;
      end else begin
        commit_d = 1'b1;
        ext_d    = (state_q == EXT) || (state_q == EXTBRK);
        brk_d    = (state_q == BRK) || (state_q == EXTBRK);
        state_d  = IDLE;
      end
    end else if (state_q != IDLE) begin
      if (to_q == TO_MAX) begin
        state_d = IDLE;
        to_d    = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      to_q     <= '0;
      commit_q <= 1'b0;
      code_q   <= 8'h00;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_q     <= to_d;
      commit_q <= commit_d;
      code_q   <= code_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
    end
  end

  assign commit_o  = commit_q;
  assign code_o    = code_q;
  assign ext_o     = ext_q;
  assign brk_o     = brk_q;
  assign pending_o = (state_q != IDLE);

endmodule

`default_nettype wire

// File: rtl/ps2_code_history.sv
// ----------------------------------------------------------------------------
// ps2_code_history : keyboard event history with counter and freezable display
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ps2_code_history
  import ps2_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int COUNT_BITS    = 8,
  parameter int FILTER_PREFIX = 1,
  parameter int DROP_REPEAT   = 1,
  parameter int TIMEOUT_CYC   = 1048576,
  parameter int DISP_BITS     = COUNT_BITS + 12 * DEPTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           code_i,
  input  logic                 code_valid_i,
  input  logic                 clear_i,
  input  logic                 freeze_i,
  output logic [DISP_BITS-1:0] display_o,
  output logic                 new_o,
  output logic                 pending_o
);

  logic       commit;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic       is_repeat;

  logic [DEPTH-1:0][ENTRY_W-1:0] entries_q, entries_d;
  logic [COUNT_BITS-1:0]         count_q, count_d;
  logic                          new_q, new_d;
  logic [DISP_BITS-1:0]          display_q, display_d;

  ps2_prefix_fsm #(
    .FILTER_PREFIX (FILTER_PREFIX),
    .TIMEOUT_CYC   (TIMEOUT_CYC)
  ) u_fsm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .code_i       (code_i),
    .code_valid_i (code_valid_i),
    .commit_o     (commit),
    .code_o       (ev_code),
    .ext_o        (ev_ext),
    .brk_o        (ev_brk),
    .pending_o    (pending_o)
  );

  assign is_repeat = (DROP_REPEAT != 0) && entries_q[0][ENTRY_W-1]
                     && (entries_q[0][9:0] == {ev_ext, ev_brk, ev_code});

  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    new_d     = 1'b0;
    display_d = display_q;
    // Clear also swallows an event that is just emerging from the FSM
    if (clear_i) begin
      entries_d = '0;
      count_d   = '0;
    end else if (commit && !is_repeat) begin
      for (int i = 1; i < DEPTH; i++) entries_d[i] = entries_q[i-1];
      entries_d[0] = make_entry(ev_ext, ev_brk, ev_code);
      count_d      = count_q + COUNT_BITS'(1);
      new_d        = 1'b1;
    end
    if (!freeze_i) display_d = {count_q, entries_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entries_q <= '0;
      count_q   <= '0;
      new_q     <= 1'b0;
      display_q <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
      new_q     <= new_d;
      display_q <= display_d;
    end
  end

  assign display_o = display_q;
  assign new_o     = new_q;

endmodule

`default_nettype wire
